calc_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `calculator` instance (4-bit `a`/`b`, 3-bit `oper`, 8-bit `out`) between two requesters. It accepts one command at a time over a valid/ready handshake and drives the calculator operands from registers. After a programmable settle time it samples `out` and returns the result with the requester ID over a valid/ready response channel. It sits between the requester logic and the calculator datapath; the calculator itself is instantiated outside this block.

---
 rtl/calc_arbiter.sv | 134 +++++++++++++
 tb/tb_calc_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_arbiter.sv
// ============================================================================
// Module   : calc_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one calculator between two
//            requesters, with a programmable settle time and a response channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_arbiter #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [2:0]       req0_oper,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req1_oper,
  output logic [3:0]       calc_a,
  output logic [3:0]       calc_b,
  output logic [2:0]       calc_oper,
  input  logic [7:0]       calc_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic             r_rr;
  logic [3:0]       r_cnt;
  logic [3:0]       r_calc_a;
  logic [3:0]       r_calc_b;
  logic [2:0]       r_calc_oper;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [7:0]       r_rsp_data;
  logic             r_busy;
  logic [CNT_W-1:0] r_op_count;

  logic w_gnt0;
  logic w_gnt1;
  logic w_idle;

  // A lone requester always wins; on contention the pointer decides.
  assign w_gnt0 = req0_valid & (~req1_valid | ~r_rr);
  assign w_gnt1 = req1_valid & (~req0_valid |  r_rr);
  assign w_idle = (r_state == IDLE);

  assign req0_ready = w_idle & w_gnt0;
  assign req1_ready = w_idle & w_gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr        <= 1'b0;
      r_cnt       <= 4'd0;
      r_calc_a    <= 4'd0;
      r_calc_b    <= 4'd0;
      r_calc_oper <= 3'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 8'd0;
      r_busy      <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_state     <= EXEC;
            r_busy      <= 1'b1;
            r_cnt       <= 4'd0;
            r_rsp_id    <= w_gnt1;
            r_rr        <= ~w_gnt1;
            r_calc_a    <= w_gnt1 ? req1_a    : req0_a;
            r_calc_b    <= w_gnt1 ? req1_b    : req0_b;
            r_calc_oper <= w_gnt1 ? req1_oper : req0_oper;
          end
        end
        EXEC: begin
          // Operands have been stable for SETTLE_CYCLES edges when this hits.
          if (r_cnt == c_settle_last) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= calc_out;
            r_op_count  <= r_op_count + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign calc_a    = r_calc_a;
  assign calc_b    = r_calc_b;
  assign calc_oper = r_calc_oper;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_calc_arbiter.sv
// ============================================================================
// Module   : tb_calc_arbiter
// Brief    : Directed self-checking bench for calc_arbiter (settle 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_arbiter;

  logic       clk = 1'b0;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_oper, req1_oper;

  // DUT with SETTLE_CYCLES=1, CNT_W=4
  logic       rst_n1;
  logic       rdy0_1, rdy1_1, rsp_valid_1, rsp_id_1, busy_1;
  logic [3:0] calc_a_1, calc_b_1, op_count_1;
  logic [2:0] calc_oper_1;
  logic [7:0] calc_out_1, rsp_data_1;

  // DUT with SETTLE_CYCLES=3, CNT_W=16
  logic        rst_n3, force_aa;
  logic        rdy0_3, rdy1_3, rsp_valid_3, rsp_id_3, busy_3;
  logic [3:0]  calc_a_3, calc_b_3;
  logic [2:0]  calc_oper_3;
  logic [7:0]  calc_out_3, rsp_data_3;
  logic [15:0] op_count_3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign calc_out_1 = {calc_a_1, calc_b_1} ^ {5'b0, calc_oper_1};
  assign calc_out_3 = force_aa ? 8'hAA : ({calc_a_3, calc_b_3} ^ {5'b0, calc_oper_3});

  calc_arbiter #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n1),
    .req0_valid(req0_valid), .req0_ready(rdy0_1), .req0_a(req0_a), .req0_b(req0_b), .req0_oper(req0_oper),
    .req1_valid(req1_valid), .req1_ready(rdy1_1), .req1_a(req1_a), .req1_b(req1_b), .req1_oper(req1_oper),
    .calc_a(calc_a_1), .calc_b(calc_b_1), .calc_oper(calc_oper_1), .calc_out(calc_out_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready), .rsp_id(rsp_id_1), .rsp_data(rsp_data_1),
    .busy(busy_1), .op_count(op_count_1)
  );

  calc_arbiter #(.SETTLE_CYCLES(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n3),
    .req0_valid(req0_valid), .req0_ready(rdy0_3), .req0_a(req0_a), .req0_b(req0_b), .req0_oper(req0_oper),
    .req1_valid(req1_valid), .req1_ready(rdy1_3), .req1_a(req1_a), .req1_b(req1_b), .req1_oper(req1_oper),
    .calc_a(calc_a_3), .calc_b(calc_b_3), .calc_oper(calc_oper_3), .calc_out(calc_out_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready), .rsp_id(rsp_id_3), .rsp_data(rsp_data_3),
    .busy(busy_3), .op_count(op_count_3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Poll dut1 until rsp_valid, bounded.
  task automatic wait_rsp1(input int bound);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!rsp_valid_1 && n < bound);
    if (!rsp_valid_1) chk("rsp1_timeout", 32'(rsp_valid_1), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_valid = 0; req1_valid = 0; rsp_ready = 0; force_aa = 0;
    req0_a = 0; req0_b = 0; req0_oper = 0; req1_a = 0; req1_b = 0; req1_oper = 0;
    rst_n1 = 0; rst_n3 = 0;
    tick(); tick();

    // Reset state
    chk("rst_rsp_valid", 32'(rsp_valid_1), 32'(0));
    chk("rst_busy",      32'(busy_1),      32'(0));
    chk("rst_op_count",  32'(op_count_1),  32'(0));
    chk("rst_calc_a",    32'(calc_a_1),    32'(0));
    chk("rst_rsp_data",  32'(rsp_data_1),  32'(0));
    chk("rst_rsp_id",    32'(rsp_id_1),    32'(0));
    rst_n1 = 1;
    tick();

    // Scenario 1: single request
    req0_valid = 1; req0_a = 4'hF; req0_b = 4'h6; req0_oper = 3'b000;
    #1;
    chk("s1_ready0", 32'(rdy0_1), 32'(1));
    chk("s1_ready1", 32'(rdy1_1), 32'(0));
    tick();
    req0_valid = 0;
    chk("s1_calc_a",    32'(calc_a_1),    32'(4'hF));
    chk("s1_calc_b",    32'(calc_b_1),    32'(4'h6));
    chk("s1_busy",      32'(busy_1),      32'(1));
    chk("s1_early_vld", 32'(rsp_valid_1), 32'(0));
    tick();
    chk("s1_rsp_valid", 32'(rsp_valid_1), 32'(1));
    chk("s1_rsp_data",  32'(rsp_data_1),  32'(8'hF6));
    chk("s1_rsp_id",    32'(rsp_id_1),    32'(0));
    chk("s1_op_count",  32'(op_count_1),  32'(1));
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("s1_rsp_done", 32'(rsp_valid_1), 32'(0));
    chk("s1_idle",     32'(busy_1),      32'(0));

    // Scenario 2: contention from reset, both held valid
    rst_n1 = 0; tick(); rst_n1 = 1;
    req0_a = 4'h1; req0_b = 4'h2; req0_oper = 3'b001;
    req1_a = 4'h3; req1_b = 4'h4; req1_oper = 3'b010;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    #1;
    chk("s2_ready0", 32'(rdy0_1), 32'(1));
    chk("s2_ready1", 32'(rdy1_1), 32'(0));
    for (int i = 0; i < 4; i++) begin
      wait_rsp1(10);
      chk($sformatf("s2_id%0d", i),   32'(rsp_id_1),   32'(i % 2));
      chk($sformatf("s2_data%0d", i), 32'(rsp_data_1), (i % 2 == 0) ? 32'h13 : 32'h36);
    end
    chk("s2_op_count", 32'(op_count_1), 32'(4));
    tick();

    // Scenario 3: backpressure on the fifth op (req0 wins again)
    rsp_ready = 0;
    wait_rsp1(10);
    chk("s3_id",   32'(rsp_id_1),   32'(0));
    chk("s3_data", 32'(rsp_data_1), 32'h13);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_valid",  32'(rsp_valid_1), 32'(1));
      chk("s3_data_h", 32'(rsp_data_1),  32'h13);
      chk("s3_id_h",   32'(rsp_id_1),    32'(0));
      chk("s3_rdy0",   32'(rdy0_1),      32'(0));
      chk("s3_rdy1",   32'(rdy1_1),      32'(0));
      chk("s3_calc",   32'({calc_a_1, calc_b_1, calc_oper_1}), 32'({4'h1, 4'h2, 3'b001}));
      chk("s3_busy",   32'(busy_1),      32'(1));
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    tick();
    chk("s3_released", 32'(rsp_valid_1), 32'(0));
    chk("s3_count",    32'(op_count_1),  32'(5));

    // Scenario 6: wrap of a 4-bit op counter after 17 ops
    req0_a = 4'h0; req0_b = 4'h0; req0_oper = 3'b000; req0_valid = 1;
    for (int i = 0; i < 12; i++) begin
      wait_rsp1(10);
      if (i == 10) chk("s6_at16", 32'(op_count_1), 32'(0));
    end
    req0_valid = 0;
    chk("s6_wrap", 32'(op_count_1), 32'(1));
    tick();
    rsp_ready = 0;

    // Scenario 4: settle 3, sample only at E0+3
    rst_n1 = 0; rst_n3 = 1;
    tick();
    req0_a = 4'h5; req0_b = 4'h9; req0_oper = 3'b011; req0_valid = 1;
    #1;
    chk("s4_ready0", 32'(rdy0_3), 32'(1));
    tick();                                 // E0
    req0_valid = 0;
    chk("s4_v0", 32'(rsp_valid_3), 32'(0));
    tick();                                 // E0+1
    chk("s4_v1", 32'(rsp_valid_3), 32'(0));
    force_aa = 1;
    tick();                                 // E0+2
    chk("s4_v2", 32'(rsp_valid_3), 32'(0));
    force_aa = 0;
    tick();                                 // E0+3
    chk("s4_v3",    32'(rsp_valid_3), 32'(1));
    chk("s4_data",  32'(rsp_data_3),  32'h5A);
    chk("s4_count", 32'(op_count_3),  32'(1));
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // Scenario 5: reset mid-EXEC
    req0_a = 4'h2; req0_b = 4'h7; req0_oper = 3'b000; req0_valid = 1;
    tick();                                 // E0
    req0_valid = 0;
    chk("s5_busy_pre", 32'(busy_3), 32'(1));
    rst_n3 = 0;
    #1;
    chk("s5_busy",   32'(busy_3),      32'(0));
    chk("s5_calc",   32'({calc_a_3, calc_b_3, calc_oper_3}), 32'(0));
    chk("s5_valid",  32'(rsp_valid_3), 32'(0));
    chk("s5_count",  32'(op_count_3),  32'(0));
    tick();
    rst_n3 = 1;
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("s5_no_rsp", 32'(rsp_valid_3), 32'(0));
    end
    chk("s5_count_end", 32'(op_count_3), 32'(0));
    chk("s5_idle_end",  32'(busy_3),     32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
